// File: rtl/typing_judge_if.sv
// typing_judge_if: game-control handshake between the control block/text ROM and the round judge.
// Ports (master drives / slave receives):
//   state[1:0]      control phase: 0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH
//   mode            locked round mode: 1 word-count round, 0 timed round
//   value[6:0]      round target in words or seconds
//   key_valid       one-cycle keystroke strobe
//   key_code[7:0]   ASCII of the typed key
//   exp_code[7:0]   ASCII of the expected character at char_addr
// Ports (slave drives / master receives):
//   finish, char_addr[6:0], words_done[6:0], correct_cnt[9:0], error_cnt[9:0], elapsed_s[6:0]
interface typing_judge_if;
    logic [1:0] state;
    logic       mode;
    logic [6:0] value;
    logic       key_valid;
    logic [7:0] key_code;
    logic [7:0] exp_code;
    logic       finish;
    logic [6:0] char_addr;
    logic [6:0] words_done;
    logic [9:0] correct_cnt;
    logic [9:0] error_cnt;
    logic [6:0] elapsed_s;

    modport master (
        output state, mode, value, key_valid, key_code, exp_code,
        input  finish, char_addr, words_done, correct_cnt, error_cnt, elapsed_s
    );

    modport slave (
        input  state, mode, value, key_valid, key_code, exp_code,
        output finish, char_addr, words_done, correct_cnt, error_cnt, elapsed_s
    );
endinterface

// File: rtl/typing_judge.sv
// typing_judge: round judge for the typing game; scores keystrokes, keeps seconds, raises finish.
// Ports:
//   clk   system clock, all state updated on the rising edge
//   rst   synchronous active-low reset
//   jb    typing_judge_if.slave: control inputs (state, mode, value), keystroke strobe and
//         expected character in; finish, char_addr and score counters out
module typing_judge #(
    parameter int TICK_DIV = 100_000_000,
    parameter int TEXT_LEN = 128
) (
    input  logic          clk,
    input  logic          rst,
    typing_judge_if.slave jb
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] SELECT = 2'd0;
    localparam logic [1:0] INGAME = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} phase_t;

    phase_t        phase, phase_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [6:0]    addr, addr_nx, words, words_nx, secs, secs_nx;
    logic [9:0]    corr, corr_nx, errs, errs_nx;
    logic [6:0]    w_run, s_run;
    logic          hit, tick, at_end, done_hit;

    always_comb begin
        hit      = jb.key_valid && jb.key_code == jb.exp_code;
        tick     = presc == PW'(TICK_DIV - 1);
        at_end   = addr == 7'(TEXT_LEN - 1);
        w_run    = (hit && jb.key_code == 8'h20 && words != 7'd127) ? words + 7'd1 : words;
        s_run    = (tick && secs != 7'd127) ? secs + 7'd1 : secs;
        // Compare against the counts this edge will register, so finish needs no extra cycle.
        done_hit = (jb.mode ? w_run >= jb.value : s_run >= jb.value) || (hit && at_end);
        phase_nx = phase;
        presc_nx = presc;
        addr_nx  = addr;
        words_nx = words;
        secs_nx  = secs;
        corr_nx  = corr;
        errs_nx  = errs;
        if (phase == RUN && jb.state == INGAME) begin
            presc_nx = tick ? '0 : presc + 1'b1;
            secs_nx  = s_run;
            words_nx = w_run;
            corr_nx  = (hit && corr != 10'h3FF) ? corr + 10'd1 : corr;
            errs_nx  = (jb.key_valid && !hit && errs != 10'h3FF) ? errs + 10'd1 : errs;
            addr_nx  = (hit && !at_end) ? addr + 7'd1 : addr;
            phase_nx = done_hit ? DONE : RUN;
        end else if (!(phase == DONE && jb.state != SELECT)) begin
            // IDLE, aborted RUN, or DONE released by SELECT: everything returns to zero.
            presc_nx = '0;
            addr_nx  = '0;
            words_nx = '0;
            secs_nx  = '0;
            corr_nx  = '0;
            errs_nx  = '0;
            phase_nx = (phase == IDLE && jb.state == INGAME) ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= IDLE;
            presc <= '0;
            addr  <= '0;
            words <= '0;
            secs  <= '0;
            corr  <= '0;
            errs  <= '0;
        end else begin
            phase <= phase_nx;
            presc <= presc_nx;
            addr  <= addr_nx;
            words <= words_nx;
            secs  <= secs_nx;
            corr  <= corr_nx;
            errs  <= errs_nx;
        end
    end

    assign jb.finish      = phase == DONE;
    assign jb.char_addr   = addr;
    assign jb.words_done  = words;
    assign jb.correct_cnt = corr;
    assign jb.error_cnt   = errs;
    assign jb.elapsed_s   = secs;
endmodule

// File: tb/tb_typing_judge.sv
// tb_typing_judge: directed scenarios plus randomized rounds checked against a behavioural model.
module tb_typing_judge;
    localparam int TICK = 4;
    localparam int TL   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typing_judge_if bus();
    logic [7:0] text [TL];
    assign bus.exp_code = text[bus.char_addr[2:0]];

    typing_judge #(.TICK_DIV(TICK), .TEXT_LEN(TL)) dut (.clk(clk), .rst(rst), .jb(bus));

    logic [41:0] dut_vec;
    assign dut_vec = {bus.finish, bus.char_addr, bus.words_done, bus.correct_cnt, bus.error_cnt, bus.elapsed_s};

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model: elapsed seconds derived from the number of RUN cycles.
    bit m_run, m_done;
    int m_cycles, m_corr, m_err, m_words, m_addr;

    function automatic int mn(int a, int b);
        return a < b ? a : b;
    endfunction

    function automatic logic [41:0] model_vec();
        return {m_done, 7'(m_addr), 7'(m_words), 10'(m_corr), 10'(m_err), 7'(mn(m_cycles / TICK, 127))};
    endfunction

    task automatic model_clear();
        m_run = 0; m_done = 0; m_cycles = 0; m_corr = 0; m_err = 0; m_words = 0; m_addr = 0;
    endtask

    task automatic model_step();
        bit ok, at_end;
        int secs;
        if (!rst) model_clear();
        else if (m_done) begin
            if (bus.state == 2'd0) model_clear();
        end else if (m_run) begin
            if (bus.state != 2'd2) model_clear();
            else begin
                m_cycles++;
                ok = bus.key_valid && bus.key_code == text[m_addr];
                at_end = 0;
                if (bus.key_valid && !ok) m_err = mn(m_err + 1, 1023);
                if (ok) begin
                    m_corr = mn(m_corr + 1, 1023);
                    if (bus.key_code == 8'h20) m_words = mn(m_words + 1, 127);
                    if (m_addr == TL - 1) at_end = 1;
                    else m_addr++;
                end
                secs = mn(m_cycles / TICK, 127);
                if ((bus.mode ? m_words : secs) >= int'(bus.value) || at_end) m_done = 1;
            end
        end else if (bus.state == 2'd2) m_run = 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_text(input string s);
        for (int i = 0; i < TL; i++) text[i] = s[i];
    endtask

    task automatic go_idle();
        bus.state = 2'd0;
        bus.key_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic enter(input logic md, input logic [6:0] val);
        bus.mode = md;
        bus.value = val;
        bus.state = 2'd2;
        cycle();
    endtask

    task automatic press(input logic [7:0] c);
        bus.key_valid = 1'b1;
        bus.key_code = c;
        cycle();
        bus.key_valid = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 2);
        return r == 0 ? 8'h61 : (r == 1 ? 8'h62 : 8'h20);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        cycle();
        cycle();
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL reset_outputs: got %h want 0", dut_vec); else n_pass++;
        rst = 1'b1;
        cycle();
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL reset_idle_hold: got %h want 0", dut_vec); else n_pass++;
    endtask

    task automatic test_timed();
        go_idle();
        enter(1'b0, 7'd3);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            n_chk++; if (bus.elapsed_s !== 7'(i / 4)) $display("FAIL timed_secs c%0d: got %0d want %0d", i, bus.elapsed_s, i / 4); else n_pass++;
            n_chk++; if (bus.finish !== (i == 12)) $display("FAIL timed_finish c%0d: got %0d want %0d", i, bus.finish, i == 12); else n_pass++;
        end
        repeat (6) cycle();
        n_chk++; if (bus.elapsed_s !== 7'd3) $display("FAIL timed_freeze: got %0d want 3", bus.elapsed_s); else n_pass++;
        n_chk++; if (bus.finish !== 1'b1) $display("FAIL timed_hold: got %0d want 1", bus.finish); else n_pass++;
    endtask

    task automatic test_word();
        go_idle();
        load_text("ab cd ef");
        enter(1'b1, 7'd2);
        press(8'h61); press(8'h62); press(8'h20); press(8'h78); press(8'h63); press(8'h64);
        n_chk++; if (bus.finish !== 1'b0) $display("FAIL word_early_finish: got %0d want 0", bus.finish); else n_pass++;
        n_chk++; if (bus.words_done !== 7'd1) $display("FAIL word_words1: got %0d want 1", bus.words_done); else n_pass++;
        press(8'h20);
        n_chk++; if (bus.error_cnt !== 10'd1) $display("FAIL word_errors: got %0d want 1", bus.error_cnt); else n_pass++;
        n_chk++; if (bus.correct_cnt !== 10'd6) $display("FAIL word_correct: got %0d want 6", bus.correct_cnt); else n_pass++;
        n_chk++; if (bus.words_done !== 7'd2) $display("FAIL word_words2: got %0d want 2", bus.words_done); else n_pass++;
        n_chk++; if (bus.char_addr !== 7'd6) $display("FAIL word_addr: got %0d want 6", bus.char_addr); else n_pass++;
        n_chk++; if (bus.finish !== 1'b1) $display("FAIL word_finish: got %0d want 1", bus.finish); else n_pass++;
    endtask

    task automatic test_return_abort();
        bus.state = 2'd3;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++; if (bus.finish !== 1'b1 || bus.correct_cnt !== 10'd6) $display("FAIL return_hold c%0d: got finish=%0d correct=%0d want 1/6", i, bus.finish, bus.correct_cnt); else n_pass++;
        end
        bus.state = 2'd0;
        cycle();
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL return_clear: got %h want 0", dut_vec); else n_pass++;
        enter(1'b1, 7'd5);
        press(8'h61);
        n_chk++; if (bus.correct_cnt !== 10'd1) $display("FAIL abort_pre: got %0d want 1", bus.correct_cnt); else n_pass++;
        bus.state = 2'd0;
        cycle();
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL abort_clear: got %h want 0", dut_vec); else n_pass++;
    endtask

    task automatic test_text_end();
        go_idle();
        enter(1'b1, 7'd100);
        for (int i = 0; i < TL - 1; i++) press(text[i]);
        n_chk++; if (bus.char_addr !== 7'd7 || bus.finish !== 1'b0) $display("FAIL end_pre: got addr=%0d finish=%0d want 7/0", bus.char_addr, bus.finish); else n_pass++;
        press(text[TL-1]);
        n_chk++; if (bus.char_addr !== 7'd7) $display("FAIL end_addr: got %0d want 7", bus.char_addr); else n_pass++;
        n_chk++; if (bus.correct_cnt !== 10'd8) $display("FAIL end_correct: got %0d want 8", bus.correct_cnt); else n_pass++;
        n_chk++; if (bus.finish !== 1'b1) $display("FAIL end_finish: got %0d want 1", bus.finish); else n_pass++;
        press(text[TL-1]);
        press(8'h7a);
        n_chk++; if (bus.correct_cnt !== 10'd8 || bus.error_cnt !== 10'd0) $display("FAIL end_ignore: got correct=%0d errors=%0d want 8/0", bus.correct_cnt, bus.error_cnt); else n_pass++;
    endtask

    task automatic test_simultaneous();
        go_idle();
        load_text(" bcdefgh");
        enter(1'b0, 7'd1);
        repeat (3) cycle();
        n_chk++; if (bus.finish !== 1'b0 || bus.elapsed_s !== 7'd0) $display("FAIL simul_pre: got finish=%0d secs=%0d want 0/0", bus.finish, bus.elapsed_s); else n_pass++;
        press(8'h20);
        n_chk++; if (bus.words_done !== 7'd1) $display("FAIL simul_words: got %0d want 1", bus.words_done); else n_pass++;
        n_chk++; if (bus.elapsed_s !== 7'd1) $display("FAIL simul_secs: got %0d want 1", bus.elapsed_s); else n_pass++;
        n_chk++; if (bus.finish !== 1'b1) $display("FAIL simul_finish: got %0d want 1", bus.finish); else n_pass++;
        go_idle();
        enter(1'b1, 7'd0);
        n_chk++; if (bus.finish !== 1'b0) $display("FAIL zero_entry: got %0d want 0", bus.finish); else n_pass++;
        cycle();
        n_chk++; if (bus.finish !== 1'b1) $display("FAIL zero_finish: got %0d want 1", bus.finish); else n_pass++;
    endtask

    task automatic test_reset_mid();
        go_idle();
        load_text("ab cd ef");
        enter(1'b0, 7'd100);
        press(8'h61);
        press(8'h62);
        repeat (5) cycle();
        n_chk++; if (bus.correct_cnt !== 10'd2 || bus.elapsed_s !== 7'd1) $display("FAIL rstmid_pre: got correct=%0d secs=%0d want 2/1", bus.correct_cnt, bus.elapsed_s); else n_pass++;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL rstmid_clear: got %h want 0", dut_vec); else n_pass++;
        bus.state = 2'd1;
        press(8'h61);
        press(8'h61);
        n_chk++; if (dut_vec !== 42'd0) $display("FAIL rstmid_quiet: got %h want 0", dut_vec); else n_pass++;
        bus.state = 2'd2;
        cycle();
        press(8'h61);
        n_chk++; if (bus.correct_cnt !== 10'd1 || bus.char_addr !== 7'd1) $display("FAIL rstmid_restart: got correct=%0d addr=%0d want 1/1", bus.correct_cnt, bus.char_addr); else n_pass++;
    endtask

    task automatic test_random();
        go_idle();
        for (int r = 0; r < 30; r++) begin
            bus.state = 2'd0;
            bus.key_valid = 1'b0;
            cycle();
            for (int i = 0; i < TL; i++) text[i] = pick();
            bus.mode = 1'($urandom_range(0, 1));
            bus.value = 7'($urandom_range(0, 6));
            bus.state = 2'd1;
            for (int c = 0; c < 50; c++) begin
                if (c == 2) bus.state = 2'd2;
                if (c == 44) bus.state = 2'd3;
                if (c > 2 && c < 44 && $urandom_range(0, 79) == 0) bus.state = 2'd0;
                rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
                bus.key_valid = 1'($urandom_range(0, 1));
                bus.key_code = ($urandom_range(0, 9) < 7) ? text[m_addr] : pick();
                cycle();
                rst = 1'b1;
                n_chk++; if (dut_vec !== model_vec()) $display("FAIL random r%0d c%0d: got %h want %h", r, c, dut_vec, model_vec()); else n_pass++;
            end
        end
    endtask

    initial begin
        model_clear();
        bus.state = 2'd0;
        bus.mode = 1'b0;
        bus.value = 7'd0;
        bus.key_valid = 1'b0;
        bus.key_code = 8'd0;
        load_text("ab cd ef");
        #1;
        test_reset();
        test_timed();
        test_word();
        test_return_abort();
        test_text_end();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/typing_judge.md
# typing_judge

Round judge for the typing game: the consuming end of the game-control handshake. It watches the control block's `state`, `value` and the locked `mode`, scores typed keystrokes against the expected text character, and keeps elapsed seconds. It raises `finish` when the round target is met (word count or time) or the text runs out, which moves the control block from INGAME to FINISH.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per elapsed second (1 s at 100 MHz).
- `TEXT_LEN`, 128: characters in the passage; valid `char_addr` range is 0..TEXT_LEN-1.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: synchronous, active-low reset, with one clock domain.
- `state` in 2: control phase: 0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
- `mode` in 1: locked round mode: 1 = word-count round, 0 = timed round.
- `value` in 7: round target, in words (mode 1) or seconds (mode 0).
- `key_valid` in 1: one-cycle strobe meaning a decoded keystroke is present.
- `key_code` in 8: ASCII code of the typed key, valid with `key_valid`.
- `exp_code` in 8: ASCII code of the expected character at `char_addr`, from the text ROM (combinational read).
- `finish` out 1: round over; high throughout DONE.
- `char_addr` out 7: index of the next expected character.
- `words_done` out 7: completed words.
- `correct_cnt` out 10: correct keystrokes, saturating at 1023.
- `error_cnt` out 10: wrong keystrokes, saturating at 1023.
- `elapsed_s` out 7: whole seconds spent in RUN, saturating at 127.

## Operation
- Internal phases are IDLE, RUN and DONE. On reset: phase IDLE, and every output, the prescaler and all counters are 0.
- **IDLE**
  - All counters, the prescaler, `char_addr` and `finish` are held at 0.
  - When `state`==INGAME, go to RUN on the next edge.
- **RUN: keystroke handling**
  - On `key_valid` with `key_code`==`exp_code`: `correct_cnt`+1.
    - If `char_addr` < TEXT_LEN-1: `char_addr`+1. At TEXT_LEN-1 it holds, and the text-end condition is set.
    - If `key_code`==8'h20 (space): `words_done`+1, saturating at 127.
  - On `key_valid` with a mismatch: `error_cnt`+1 and `char_addr` unchanged.
- **RUN: timing**
  - The prescaler counts 0..TICK_DIV-1.
  - At wrap, `elapsed_s`+1.
- **RUN: finish conditions** (any one ends the round)
  - mode 1 and next `words_done` >= `value`.
  - mode 0 and next `elapsed_s` >= `value`.
  - A correct key at `char_addr`==TEXT_LEN-1.
  - When a condition holds, the phase becomes DONE on the same edge that applies the final counter update.
- **RUN: abort**
  - If `state` leaves INGAME without DONE having been reached (for example SELECT is forced), go to IDLE and clear everything.
- **DONE**
  - `finish`=1.
  - Counters freeze, for score display.
  - `key_valid` and the prescaler are ignored.
  - When `state`==SELECT, go to IDLE (clearing) on the next edge.
  - Any other `state`, including FINISH, keeps DONE.
- **Simultaneous events:** a keystroke and a second tick in the same cycle are both applied. Either may trigger DONE.
- **`value`==0:** RUN lasts exactly one cycle, then DONE, whatever the inputs (the >= compare).
- **Changes to `mode`/`value` during RUN** take effect immediately. Control locks them, so this does not occur in practice.

## Timing
- IDLE→RUN: `state` becomes INGAME at edge k; RUN is in effect from edge k+1.
  - The first prescaler count occurs at edge k+1.
  - The first second is registered TICK_DIV cycles after entry.
- Keystroke with `key_valid` high in cycle n: counters and `char_addr` are updated at edge n+1, so `exp_code` for the new address is needed from cycle n+1.
- `finish` rises on the same edge as the final counter update, with zero extra latency. It stays high until the edge after `state`==SELECT is seen.
- Back-to-back `key_valid` on every cycle is supported; each strobe is scored against the `exp_code` present in its cycle.
- Reset mid-round: on the first edge with `rst`=0, everything returns to reset values. `finish` drops that edge.

## Test plan
All scenarios run with TICK_DIV=4 and TEXT_LEN=8.
- **Timed round:** mode 0, value 3, `state`=INGAME, no keys → `elapsed_s` reaches 1, 2, 3 at 4, 8, 12 cycles after entry. `finish`=1 on the edge where `elapsed_s`=3, then holds.
- **Word round:** mode 1, value 2, text "ab cd ef"; type a, b, space, x (wrong), c, d, space → `error_cnt`=1, `correct_cnt`=6, `words_done`=2. `finish` goes high with the second space, and `char_addr`=6.
- **Text end:** mode 1, value 100; type all 8 characters correctly → `char_addr` holds at 7, `correct_cnt`=8, `finish`=1. A further key is ignored.
- **Simultaneous and edge case:** a correct space coincides with a second wrap in mode 0 with value 1 → `words_done`=1, `elapsed_s`=1, `finish`=1 on the same edge. Separately, value 0 → `finish` one cycle after entering RUN.
- **Return and abort:** after DONE, hold `state`=FINISH for 5 cycles → `finish` stays 1. Then `state`=SELECT → all outputs 0 the next edge. A mid-RUN switch to SELECT also clears.
- **Reset:** drive `rst`=0 for one edge mid-RUN with counters nonzero → all outputs 0 and phase IDLE. No activity until `state`=INGAME is seen again.
